// File: rtl/led_blink_sched.sv
// rtl/led_blink_sched.sv - shared LED blink generator, round-robin owners (LED_SCHED_PRIORITY_EN: fixed priority)
module led_blink_sched #(
    parameter int NREQ        = 4,
    parameter int HALF_PERIOD = 2**24,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] count,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  blink,
    output logic                  busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int PH_W  = $clog2(HALF_PERIOD);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

    state_t             state, state_nxt;
    logic [PH_W-1:0]    ph_cnt, ph_cnt_nxt;
    logic [CNT_W-1:0]   remaining, remaining_nxt, rem_dec, cnt_sel;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [NREQ-1:0]    grant_nxt, done_nxt;
    logic               blink_nxt;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               phase_end;

`ifdef LED_SCHED_PRIORITY_EN
    // Fixed priority: scanning downwards leaves the lowest set index as the winner.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr;
    int               rr_idx;

    // Round-robin: scan from the farthest candidate inwards so the one right after rr_ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        rr_idx     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            rr_idx = (int'(rr_ptr) + k) % NREQ;
            if (req[rr_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(rr_idx);
            end
        end
    end

    // Remember the last owner; reset value makes requester 0 the first candidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= IDX_W'(NREQ - 1);
        end else if (state == S_IDLE && pick_valid) begin
            rr_ptr <= pick_idx;
        end
    end
`endif

    assign phase_end = (ph_cnt == PH_LAST);
    assign rem_dec   = (remaining != '0) ? remaining - 1'b1 : '0;
    assign cnt_sel   = count[int'(pick_idx)*CNT_W +: CNT_W];
    assign busy      = (state != S_IDLE);

    // Next-state and next-output logic; all visible outputs are registered below.
    always_comb begin
        state_nxt     = state;
        ph_cnt_nxt    = ph_cnt + 1'b1;
        remaining_nxt = remaining;
        owner_nxt     = owner;
        grant_nxt     = grant;
        done_nxt      = '0;
        blink_nxt     = blink;
        case (state)
            S_IDLE: begin
                ph_cnt_nxt = '0;
                grant_nxt  = '0;
                blink_nxt  = 1'b0;
                if (pick_valid) begin
                    state_nxt     = S_ON;
                    owner_nxt     = pick_idx;
                    grant_nxt     = NREQ'(1) << pick_idx;
                    blink_nxt     = 1'b1;
                    remaining_nxt = (cnt_sel == '0) ? CNT_W'(1) : cnt_sel;
                end
            end
            S_ON, S_OFF: begin
                if (!req[owner]) begin
                    // Owner withdrew: drop the LED immediately, no done pulse.
                    state_nxt  = S_GAP;
                    ph_cnt_nxt = '0;
                    grant_nxt  = '0;
                    blink_nxt  = 1'b0;
                end else if (phase_end) begin
                    ph_cnt_nxt = '0;
                    if (state == S_ON) begin
                        state_nxt = S_OFF;
                        blink_nxt = 1'b0;
                    end else begin
                        remaining_nxt = rem_dec;
                        if (rem_dec == '0) begin
                            state_nxt = S_GAP;
                            grant_nxt = '0;
                            done_nxt  = NREQ'(1) << owner;
                        end else begin
                            state_nxt = S_ON;
                            blink_nxt = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                grant_nxt = '0;
                blink_nxt = 1'b0;
                if (phase_end) begin
                    state_nxt  = S_IDLE;
                    ph_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt  = S_IDLE;
                ph_cnt_nxt = '0;
                grant_nxt  = '0;
                blink_nxt  = 1'b0;
            end
        endcase
    end

    // State, phase counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ph_cnt    <= '0;
            remaining <= '0;
            owner     <= '0;
            grant     <= '0;
            done      <= '0;
            blink     <= 1'b0;
        end else begin
            state     <= state_nxt;
            ph_cnt    <= ph_cnt_nxt;
            remaining <= remaining_nxt;
            owner     <= owner_nxt;
            grant     <= grant_nxt;
            done      <= done_nxt;
            blink     <= blink_nxt;
        end
    end

endmodule

// File: tb/tb_led_blink_sched.sv
// tb/tb_led_blink_sched.sv - directed self-checking bench for led_blink_sched
module tb_led_blink_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] count;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        blink;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    led_blink_sched #(.NREQ(4), .HALF_PERIOD(4), .CNT_W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .count (count),
        .grant (grant),
        .done  (done),
        .blink (blink),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clocks, checking {grant, done, blink, busy} 1 time unit after each edge.
    task automatic expect_n(input int n, input logic [3:0] g, input logic [3:0] d,
                            input logic b, input logic bz, input string tag);
        logic [9:0] obs;
        logic [9:0] exp;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            obs = {grant, done, blink, busy};
            exp = {g, d, b, bz};
            n_assert++;
            assert (obs === exp) else begin
                n_fail++;
                $error("FAIL %s cycle %0d: observed g/d/b/busy=%b expected=%b", tag, i, obs, exp);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = 4'b0000;
        count = 16'h0000;
        expect_n(2, 4'b0000, 4'b0000, 1'b0, 1'b0, "reset");

        // Requester 0, two blinks.
        rst   = 1'b0;
        req   = 4'b0001;
        count = 16'h0002;
        expect_n(4, 4'b0001, 4'b0000, 1'b1, 1'b1, "s1_on1");
        expect_n(4, 4'b0001, 4'b0000, 1'b0, 1'b1, "s1_off1");
        expect_n(4, 4'b0001, 4'b0000, 1'b1, 1'b1, "s1_on2");
        expect_n(4, 4'b0001, 4'b0000, 1'b0, 1'b1, "s1_off2");
        expect_n(1, 4'b0000, 4'b0001, 1'b0, 1'b1, "s1_done");
        req = 4'b0000;
        expect_n(3, 4'b0000, 4'b0000, 1'b0, 1'b1, "s1_gap");
        expect_n(2, 4'b0000, 4'b0000, 1'b0, 1'b0, "s1_idle");

        // Round-robin between requesters 0 and 2 from a fresh reset.
        rst = 1'b1;
        expect_n(1, 4'b0000, 4'b0000, 1'b0, 1'b0, "s2_reset");
        rst   = 1'b0;
        req   = 4'b0101;
        count = 16'h1111;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] g;
            g = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            expect_n(4, g, 4'b0000, 1'b1, 1'b1, "s2_on");
            expect_n(4, g, 4'b0000, 1'b0, 1'b1, "s2_off");
            expect_n(1, 4'b0000, g, 1'b0, 1'b1, "s2_done");
            expect_n(3, 4'b0000, 4'b0000, 1'b0, 1'b1, "s2_gap");
            expect_n(1, 4'b0000, 4'b0000, 1'b0, 1'b0, "s2_idle");
        end

        // Requester 2 aborts during its second ON phase.
        req   = 4'b0100;
        count = 16'h0300;
        expect_n(4, 4'b0100, 4'b0000, 1'b1, 1'b1, "s3_on1");
        expect_n(4, 4'b0100, 4'b0000, 1'b0, 1'b1, "s3_off1");
        expect_n(2, 4'b0100, 4'b0000, 1'b1, 1'b1, "s3_on2");
        req = 4'b0000;
        expect_n(4, 4'b0000, 4'b0000, 1'b0, 1'b1, "s3_abort_gap");
        expect_n(1, 4'b0000, 4'b0000, 1'b0, 1'b0, "s3_idle");

        // Count of zero gives exactly one blink.
        req   = 4'b0010;
        count = 16'h0000;
        expect_n(4, 4'b0010, 4'b0000, 1'b1, 1'b1, "s4_on");
        expect_n(4, 4'b0010, 4'b0000, 1'b0, 1'b1, "s4_off");
        expect_n(1, 4'b0000, 4'b0010, 1'b0, 1'b1, "s4_done");
        req = 4'b0000;
        expect_n(3, 4'b0000, 4'b0000, 1'b0, 1'b1, "s4_gap");
        expect_n(1, 4'b0000, 4'b0000, 1'b0, 1'b0, "s4_idle");

        // Reset mid-OFF, then requester 3 wins the first grant afterwards.
        req   = 4'b0001;
        count = 16'h0005;
        expect_n(4, 4'b0001, 4'b0000, 1'b1, 1'b1, "s5_on");
        expect_n(2, 4'b0001, 4'b0000, 1'b0, 1'b1, "s5_off");
        rst = 1'b1;
        req = 4'b1000;
        expect_n(1, 4'b0000, 4'b0000, 1'b0, 1'b0, "s5_reset");
        rst = 1'b0;
        expect_n(4, 4'b1000, 4'b0000, 1'b1, 1'b1, "s5_on_r3");
        expect_n(1, 4'b1000, 4'b0000, 1'b0, 1'b1, "s5_off_r3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
